// File: rtl/q_sys_log_writer.sv
// Circular-buffer capture engine: streams DAQ samples into the log RAM as an
// Avalon-MM write master and records where the trigger and pre-trigger window landed.
module q_sys_log_writer #(
  parameter int ADDR_W     = 14,
  parameter int DATA_W     = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              arm,
  input  logic              abort,
  input  logic [ADDR_W-1:0] pre_len,
  input  logic [ADDR_W-1:0] post_len,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic              trig,
  output logic [ADDR_W-1:0] avm_address,
  output logic [1:0]        avm_byteenable,
  output logic              avm_chipselect,
  output logic              avm_write,
  output logic [DATA_W-1:0] avm_writedata,
  input  logic              avm_waitrequest,
  output logic              busy,
  output logic              done,
  output logic              overflow,
  output logic [ADDR_W-1:0] trig_addr,
  output logic [ADDR_W-1:0] start_addr
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [2:0] {
    IDLE, PRE, WAIT_TRIG, POST, FLUSH, DONE, ABORT
  } state_t;

  state_t state, state_nxt;

  logic [ADDR_W-1:0] pre_q, post_q;
  logic [ADDR_W-1:0] len_cnt, len_cnt_nxt;
  logic [ADDR_W:0]   cnt_inc;

  logic [DATA_W:0]   mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  count;
  logic [CNT_W:0]    occ;
  logic              out_tag;

  logic active, full, accept, drop, complete, pending;
  logic arm_go, abort_go, fifo_clr, trig_hit, load;

  // The entry sitting in the output register counts against FIFO_DEPTH,
  // so the whole engine buffers at most FIFO_DEPTH samples.
  assign occ      = {1'b0, count} + (CNT_W+1)'(avm_write);
  assign full     = occ >= (CNT_W+1)'(FIFO_DEPTH);
  assign active   = (state == PRE) || (state == WAIT_TRIG) || (state == POST);
  assign accept   = active && in_valid && !full;
  assign drop     = active && in_valid && full;
  assign complete = avm_write && !avm_waitrequest;
  assign pending  = avm_write && avm_waitrequest;
  assign arm_go   = arm && !abort && ((state == IDLE) || (state == DONE));
  assign abort_go = abort && (state != ABORT);
  assign fifo_clr = arm_go || abort_go;
  assign trig_hit = accept && (state == WAIT_TRIG) && trig;
  assign load     = (count != '0) && !pending && !fifo_clr;
  assign cnt_inc  = {1'b0, len_cnt} + 1'b1;

  assign busy           = (state == PRE) || (state == WAIT_TRIG) || (state == POST) || (state == FLUSH);
  assign done           = (state == DONE);
  assign avm_chipselect = avm_write;
  assign avm_byteenable = {2{avm_write}};

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state   <= IDLE;
      len_cnt <= '0;
      pre_q   <= '0;
      post_q  <= '0;
    end else begin
      state   <= state_nxt;
      len_cnt <= len_cnt_nxt;
      if (arm_go) begin
        pre_q  <= pre_len;
        post_q <= (post_len == '0) ? ADDR_W'(1) : post_len;
      end
    end
  end

  always_comb begin
    state_nxt   = state;
    len_cnt_nxt = len_cnt;
    case (state)
      IDLE, DONE: begin
        if (arm_go) begin
          state_nxt   = PRE;
          len_cnt_nxt = '0;
        end
      end
      PRE: begin
        if (len_cnt == pre_q) begin
          state_nxt   = WAIT_TRIG;
          len_cnt_nxt = '0;
        end else if (accept) begin
          len_cnt_nxt = cnt_inc[ADDR_W-1:0];
          if (cnt_inc == {1'b0, pre_q}) state_nxt = WAIT_TRIG;
        end
      end
      WAIT_TRIG: begin
        // The trigger sample is the first of the post-trigger window.
        if (trig_hit) begin
          len_cnt_nxt = ADDR_W'(1);
          state_nxt   = (post_q == ADDR_W'(1)) ? FLUSH : POST;
        end
      end
      POST: begin
        if (accept) begin
          len_cnt_nxt = cnt_inc[ADDR_W-1:0];
          if (cnt_inc == {1'b0, post_q}) state_nxt = FLUSH;
        end
      end
      FLUSH: begin
        if ((count == '0) && !pending) state_nxt = DONE;
      end
      ABORT: begin
        if (!pending) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    // A stalled write must still finish before the engine can return to IDLE.
    if (abort_go) state_nxt = pending ? ABORT : IDLE;
  end

  always_ff @(posedge clk) begin
    if (accept && !fifo_clr) mem[wr_ptr] <= {trig_hit, in_data};
  end

  always_ff @(posedge clk) begin
    if (!reset_n || fifo_clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (accept) wr_ptr <= wr_ptr + 1'b1;
      if (load)   rd_ptr <= rd_ptr + 1'b1;
      case ({accept, load})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // avm_address doubles as the ring write pointer.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      avm_write     <= 1'b0;
      avm_writedata <= '0;
      avm_address   <= '0;
      out_tag       <= 1'b0;
    end else begin
      if (arm_go)        avm_address <= '0;
      else if (complete) avm_address <= avm_address + 1'b1;
      if (load) begin
        avm_write     <= 1'b1;
        avm_writedata <= mem[rd_ptr][DATA_W-1:0];
        out_tag       <= mem[rd_ptr][DATA_W];
      end else if (complete) begin
        avm_write <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      overflow   <= 1'b0;
      trig_addr  <= '0;
      start_addr <= '0;
    end else if (arm_go) begin
      overflow   <= 1'b0;
      trig_addr  <= '0;
      start_addr <= '0;
    end else begin
      if (drop) overflow <= 1'b1;
      if (complete && out_tag) begin
        trig_addr  <= avm_address;
        start_addr <= avm_address - pre_q;
      end
    end
  end

endmodule

// File: tb/tb_q_sys_log_writer.sv
// Self-checking bench for q_sys_log_writer: a queue-based capture model is compared
// every cycle, and directed scenarios pin the model with hand-computed results.
module tb_q_sys_log_writer;

  localparam int MASK = 16383;

  logic        clk = 1'b0;
  logic        reset_n, arm, abort, in_valid, trig, avm_waitrequest;
  logic [13:0] pre_len, post_len;
  logic [15:0] in_data;
  logic [13:0] avm_address, trig_addr, start_addr;
  logic [1:0]  avm_byteenable;
  logic        avm_chipselect, avm_write, busy, done, overflow;
  logic [15:0] avm_writedata;

  int assertions = 0;
  int failures   = 0;
  bit checkEn    = 0;
  int dutWrites  = 0;
  logic [15:0] ram [16384];

  // Model state: mode 0 idle, 1 pre, 2 wait trigger, 3 post, 4 flush, 5 done, 6 abort wait
  logic [16:0] mq [$];
  bit          mv;
  logic [16:0] me;
  int mwptr, mmode, mcnt, mpre, mpost, mtrig, mstart;
  bit movf;

  q_sys_log_writer dut (
    .clk(clk), .reset_n(reset_n), .arm(arm), .abort(abort),
    .pre_len(pre_len), .post_len(post_len),
    .in_valid(in_valid), .in_data(in_data), .trig(trig),
    .avm_address(avm_address), .avm_byteenable(avm_byteenable),
    .avm_chipselect(avm_chipselect), .avm_write(avm_write),
    .avm_writedata(avm_writedata), .avm_waitrequest(avm_waitrequest),
    .busy(busy), .done(done), .overflow(overflow),
    .trig_addr(trig_addr), .start_addr(start_addr)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    assertions++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input bit v, input logic [15:0] d, input bit t, input bit w);
    in_valid        = v;
    in_data         = d;
    trig            = t;
    avm_waitrequest = w;
    arm             = 1'b0;
    abort           = 1'b0;
  endtask

  // Behavioural capture model: a bounded queue of pending samples plus one
  // in-flight write, with the capture window counted in samples.
  always @(posedge clk) begin : model
    bit comp, pend, acc, cap, isFull, tagBit;
    int qs;
    if (!reset_n) begin
      mq.delete();
      mv = 0; me = '0; mwptr = 0; mmode = 0; mcnt = 0;
      movf = 0; mtrig = 0; mstart = 0;
    end else begin
      qs     = mq.size();
      pend   = mv && avm_waitrequest;
      comp   = mv && !avm_waitrequest;
      cap    = (mmode >= 1) && (mmode <= 3);
      isFull = (qs + int'(mv)) >= 4;
      acc    = cap && in_valid && !isFull;
      tagBit = 0;
      if (cap && in_valid && isFull) movf = 1;
      if (comp) begin
        if (me[16]) begin
          mtrig  = mwptr;
          mstart = (mwptr - mpre) & MASK;
        end
        mwptr = (mwptr + 1) & MASK;
        mv    = 0;
      end
      if (abort && mmode != 6) begin
        mq.delete();
        mmode = pend ? 6 : 0;
      end else if (arm && (mmode == 0 || mmode == 5)) begin
        mpre  = int'(pre_len);
        mpost = (post_len == 0) ? 1 : int'(post_len);
        mwptr = 0; mq.delete(); movf = 0; mtrig = 0; mstart = 0; mcnt = 0;
        mmode = 1;
      end else begin
        if (!mv && qs > 0) begin
          me = mq.pop_front();
          mv = 1;
        end
        case (mmode)
          1: if (mcnt == mpre) mmode = 2;
             else if (acc) begin
               mcnt++;
               if (mcnt == mpre) mmode = 2;
             end
          2: if (acc && trig) begin
               tagBit = 1;
               mcnt   = 1;
               mmode  = (mpost == 1) ? 4 : 3;
             end
          3: if (acc) begin
               mcnt++;
               if (mcnt == mpost) mmode = 4;
             end
          4: if (qs == 0 && !pend) mmode = 5;
          6: if (!pend) mmode = 0;
          default: ;
        endcase
        if (acc) mq.push_back({tagBit, in_data});
      end
    end
  end

  // Record what actually reached the RAM.
  always @(posedge clk) begin
    if (reset_n && avm_write && !avm_waitrequest) begin
      ram[avm_address] = avm_writedata;
      dutWrites++;
    end
  end

  always @(negedge clk) begin
    if (checkEn) begin
      checkOutput("avm_write", 32'(avm_write), 32'(mv));
      checkOutput("avm_address", 32'(avm_address), 32'(mwptr));
      if (mv) checkOutput("avm_writedata", 32'(avm_writedata), 32'(me[15:0]));
      checkOutput("avm_byteenable", 32'(avm_byteenable), mv ? 32'd3 : 32'd0);
      checkOutput("avm_chipselect", 32'(avm_chipselect), 32'(mv));
      checkOutput("busy", 32'(busy), 32'((mmode >= 1) && (mmode <= 4)));
      checkOutput("done", 32'(done), 32'(mmode == 5));
      checkOutput("overflow", 32'(overflow), 32'(movf));
      checkOutput("trig_addr", 32'(trig_addr), 32'(mtrig));
      checkOutput("start_addr", 32'(start_addr), 32'(mstart));
    end
  end

  task automatic armCapture(input int pre, input int post);
    @(negedge clk);
    applyStimulus(0, '0, 0, 0);
    pre_len   = 14'(pre);
    post_len  = 14'(post);
    arm       = 1'b1;
    dutWrites = 0;
  endtask

  task automatic runStream(input int t1, input int t2, input int stallStart, input int stallLen, input int budget);
    int k = 0;
    bit finished = 0;
    while (k < budget && !finished) begin
      @(negedge clk);
      if (mmode == 5) finished = 1;
      else begin
        applyStimulus(1, 16'(k), (k == t1) || (k == t2),
                      (k >= stallStart) && (k < stallStart + stallLen));
        k++;
      end
    end
    applyStimulus(0, '0, 0, 0);
    if (!finished) begin
      assertions++;
      failures++;
      $display("[TB] FAIL doneTimeout: got busy %0d expected done within %0d cycles", busy, budget);
    end
  endtask

  task automatic checkRecord(input string tag, input int writes, input int ta, input int sa);
    checkOutput({tag, "_writes"}, 32'(dutWrites), 32'(writes));
    checkOutput({tag, "_done"}, 32'(done), 32'd1);
    checkOutput({tag, "_trig_addr"}, 32'(trig_addr), 32'(ta));
    checkOutput({tag, "_start_addr"}, 32'(start_addr), 32'(sa));
    checkOutput({tag, "_model_trig"}, 32'(mtrig), 32'(ta));
  endtask

  initial begin
    applyStimulus(0, '0, 0, 0);
    pre_len  = '0;
    post_len = '0;
    reset_n  = 1'b0;
    @(posedge clk);
    checkEn = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_done", 32'(done), 32'd0);
    checkOutput("reset_avm_write", 32'(avm_write), 32'd0);
    checkOutput("reset_overflow", 32'(overflow), 32'd0);
    reset_n = 1'b1;

    $display("[TB] basic capture pre=4 post=4");
    armCapture(4, 4);
    runStream(6, -1, -1, 0, 100);
    checkRecord("basic", 10, 6, 2);
    checkOutput("basic_overflow", 32'(overflow), 32'd0);
    for (int i = 0; i < 10; i++) checkOutput("basic_ram", 32'(ram[i]), 32'(i));

    $display("[TB] trigger during PRE ignored");
    armCapture(4, 2);
    runStream(2, 7, -1, 0, 100);
    checkRecord("pretrig", 9, 7, 3);
    checkOutput("pretrig_ram7", 32'(ram[7]), 32'd7);

    $display("[TB] pre=0, full-depth post window");
    armCapture(0, 16383);
    @(negedge clk);
    applyStimulus(0, '0, 0, 0);
    runStream(0, -1, -1, 0, 17000);
    checkRecord("fulldepth", 16383, 0, 0);
    checkOutput("fulldepth_ram_last", 32'(ram[16382]), 32'd16382);
    checkOutput("fulldepth_wptr", 32'(avm_address), 32'd16383);

    $display("[TB] ring wrap");
    armCapture(8, 3);
    runStream(16389, -1, -1, 0, 16500);
    checkRecord("wrap", 16392, 5, 16381);
    checkOutput("wrap_ram0", 32'(ram[0]), 32'd16384);
    checkOutput("wrap_ram5", 32'(ram[5]), 32'd16389);
    checkOutput("wrap_ram7", 32'(ram[7]), 32'd16391);
    checkOutput("wrap_ram8", 32'(ram[8]), 32'd8);
    checkOutput("wrap_ram16383", 32'(ram[16383]), 32'd16383);

    $display("[TB] waitrequest stall with overflow");
    armCapture(4, 20);
    runStream(5, -1, 8, 10, 200);
    checkRecord("stall", 25, 5, 1);
    checkOutput("stall_overflow", 32'(overflow), 32'd1);
    checkOutput("stall_ram9", 32'(ram[9]), 32'd9);
    checkOutput("stall_ram10", 32'(ram[10]), 32'd19);

    $display("[TB] abort with pending write");
    armCapture(2, 10);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      applyStimulus(1, 16'(k), k == 3, k >= 8);
    end
    @(negedge clk);
    checkOutput("abort_pending_before", 32'(avm_write), 32'd1);
    applyStimulus(0, '0, 0, 1);
    abort = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      applyStimulus(0, '0, 0, 1);
      checkOutput("abort_write_held", 32'(avm_write), 32'd1);
      checkOutput("abort_busy", 32'(busy), 32'd0);
    end
    @(negedge clk);
    applyStimulus(0, '0, 0, 0);
    @(negedge clk);
    checkOutput("abort_write_released", 32'(avm_write), 32'd0);
    checkOutput("abort_done", 32'(done), 32'd0);
    checkOutput("abort_trig_kept", 32'(trig_addr), 32'd3);
    checkOutput("abort_start_kept", 32'(start_addr), 32'd1);

    $display("[TB] reset mid-POST");
    armCapture(1, 100);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      applyStimulus(1, 16'(k + 100), k == 2, 0);
    end
    @(negedge clk);
    checkOutput("midpost_busy", 32'(busy), 32'd1);
    reset_n = 1'b0;
    @(negedge clk);
    applyStimulus(0, '0, 0, 0);
    checkOutput("rst_avm_write", 32'(avm_write), 32'd0);
    checkOutput("rst_avm_address", 32'(avm_address), 32'd0);
    checkOutput("rst_avm_writedata", 32'(avm_writedata), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_trig_addr", 32'(trig_addr), 32'd0);
    checkOutput("rst_start_addr", 32'(start_addr), 32'd0);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
